// File: rtl/step_fsm_seq_scheduler_if.sv
`default_nettype none
// ============================================================================
// step_fsm_seq_scheduler_if: requester handshake and FSM lane bus
// Revision: 1.0
// ============================================================================
interface step_fsm_seq_scheduler_if #(
  parameter int IO_SIZE_G = 3
);
  logic [1:0]           req_i;
  logic [1:0]           gnt_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  logic                 fault_o;
  logic [IO_SIZE_G-1:0] fsm_data_a_o;
  logic [IO_SIZE_G-1:0] fsm_data_b_o;
  logic [IO_SIZE_G-1:0] fsm_data_c_o;
  logic [IO_SIZE_G-1:0] fsm_state_a_i;
  logic [IO_SIZE_G-1:0] fsm_state_b_i;
  logic [IO_SIZE_G-1:0] fsm_state_c_i;
  logic [7:0]           mismatch_cnt_o;

  modport master (
    output req_i, fsm_state_a_i, fsm_state_b_i, fsm_state_c_i,
    input  gnt_o, busy_o, done_o, err_o, fault_o,
           fsm_data_a_o, fsm_data_b_o, fsm_data_c_o, mismatch_cnt_o
  );

  modport slave (
    input  req_i, fsm_state_a_i, fsm_state_b_i, fsm_state_c_i,
    output gnt_o, busy_o, done_o, err_o, fault_o,
           fsm_data_a_o, fsm_data_b_o, fsm_data_c_o, mismatch_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/step_fsm_seq_scheduler.sv
`default_nettype none
// ============================================================================
// step_fsm_seq_scheduler: round-robin sequencer/checker for the TMR step FSM
// Revision: 1.0
// ============================================================================
module step_fsm_seq_scheduler #(
  parameter int                     IO_SIZE_G         = 3,
  parameter logic [4*IO_SIZE_G-1:0] SEQ0_WORDS_G      = '0,
  parameter logic [4*IO_SIZE_G-1:0] SEQ0_STATES_G     = '0,
  parameter logic [4*IO_SIZE_G-1:0] SEQ1_WORDS_G      = '0,
  parameter logic [4*IO_SIZE_G-1:0] SEQ1_STATES_G     = '0,
  parameter logic [IO_SIZE_G-1:0]   IDLE_WORD_G       = '0,
  parameter logic [IO_SIZE_G-1:0]   IDLE_STATE_G      = '0,
  parameter int                     RECOVER_TIMEOUT_G = 16
) (
  input  wire logic               clk_i,
  input  wire logic               rst_i,
  step_fsm_seq_scheduler_if.slave bus
);

  localparam int                c_TCNT_W    = (RECOVER_TIMEOUT_G > 1) ? $clog2(RECOVER_TIMEOUT_G) : 1;
  localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(RECOVER_TIMEOUT_G - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RECOVER = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic [IO_SIZE_G-1:0] f_word(input logic [4*IO_SIZE_G-1:0] vec,
                                                  input logic [1:0]             k);
    f_word = vec[int'(k)*IO_SIZE_G +: IO_SIZE_G];
  endfunction

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_gnt, w_gnt_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_fault, w_fault_nxt;
  logic [IO_SIZE_G-1:0]  r_data, w_data_nxt;
  logic [7:0]            r_mcnt, w_mcnt_nxt;
  logic [1:0]            r_idx, w_idx_nxt;
  logic                  r_seq_err, w_seq_err_nxt;
  logic [c_TCNT_W-1:0]   r_tcnt, w_tcnt_nxt;
  logic                  r_last, w_last_nxt;

  logic [4*IO_SIZE_G-1:0] w_words;
  logic [4*IO_SIZE_G-1:0] w_states;
  logic [IO_SIZE_G-1:0]   w_maj;
  logic [IO_SIZE_G-1:0]   w_exp;
  logic [1:0]             w_exp_idx;
  logic                   w_check;
  logic                   w_bad;
  logic                   w_diff;
  logic                   w_all_idle;
  logic                   w_pick1;

  assign w_words  = r_gnt[1] ? SEQ1_WORDS_G  : SEQ0_WORDS_G;
  assign w_states = r_gnt[1] ? SEQ1_STATES_G : SEQ0_STATES_G;

  assign w_maj = (bus.fsm_state_a_i & bus.fsm_state_b_i) |
                 (bus.fsm_state_a_i & bus.fsm_state_c_i) |
                 (bus.fsm_state_b_i & bus.fsm_state_c_i);

  assign w_all_idle = (bus.fsm_state_a_i == IDLE_STATE_G) &&
                      (bus.fsm_state_b_i == IDLE_STATE_G) &&
                      (bus.fsm_state_c_i == IDLE_STATE_G);

  // Requester 1 wins when alone, or on contention when requester 0 went last.
  assign w_pick1 = bus.req_i[1] & (~bus.req_i[0] | ~r_last);

  // The state inputs lag the driven word by one cycle, hence expected[idx-1].
  always_comb begin
    w_check   = 1'b0;
    w_exp_idx = 2'd0;
    if (r_state == ST_SEND && r_idx != 2'd0) begin
      w_check   = 1'b1;
      w_exp_idx = r_idx - 2'd1;
    end else if (r_state == ST_CHECK) begin
      w_check   = 1'b1;
      w_exp_idx = 2'd3;
    end
  end

  assign w_exp  = f_word(w_states, w_exp_idx);
  assign w_bad  = w_check && (w_maj != w_exp);
  assign w_diff = w_check && !((bus.fsm_state_a_i == bus.fsm_state_b_i) &&
                               (bus.fsm_state_b_i == bus.fsm_state_c_i));

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_data_nxt    = IDLE_WORD_G;
    w_idx_nxt     = r_idx;
    w_seq_err_nxt = r_seq_err | w_bad;
    w_tcnt_nxt    = r_tcnt;
    w_last_nxt    = r_last;
    w_fault_nxt   = r_fault;
    w_mcnt_nxt    = (w_diff && r_mcnt != 8'hFF) ? r_mcnt + 8'd1 : r_mcnt;

    case (r_state)
      ST_IDLE: begin
        if (bus.req_i != 2'b00) begin
          w_gnt_nxt     = w_pick1 ? 2'b10 : 2'b01;
          w_data_nxt    = f_word(w_pick1 ? SEQ1_WORDS_G : SEQ0_WORDS_G, 2'd0);
          w_idx_nxt     = 2'd0;
          w_seq_err_nxt = 1'b0;
          w_state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        w_idx_nxt = r_idx + 2'd1;
        if (r_idx != 2'd3) begin
          w_data_nxt = f_word(w_words, r_idx + 2'd1);
        end else begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_seq_err_nxt) begin
          w_tcnt_nxt  = '0;
          w_state_nxt = ST_RECOVER;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_RECOVER: begin
        if (w_all_idle) begin
          w_state_nxt = ST_DONE;
        end else if (r_tcnt == c_TCNT_LAST) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_tcnt_nxt = r_tcnt + c_TCNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // The grant is released as the DONE pulse is launched.
    if (w_state_nxt == ST_DONE) begin
      w_gnt_nxt  = 2'b00;
      w_last_nxt = r_gnt[1];
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
    w_err_nxt  = (w_state_nxt == ST_DONE) ? w_seq_err_nxt : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 2'b00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_fault   <= 1'b0;
      r_data    <= IDLE_WORD_G;
      r_mcnt    <= 8'd0;
      r_idx     <= 2'd0;
      r_seq_err <= 1'b0;
      r_tcnt    <= '0;
      r_last    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_fault   <= w_fault_nxt;
      r_data    <= w_data_nxt;
      r_mcnt    <= w_mcnt_nxt;
      r_idx     <= w_idx_nxt;
      r_seq_err <= w_seq_err_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign bus.gnt_o          = r_gnt;
  assign bus.busy_o         = r_busy;
  assign bus.done_o         = r_done;
  assign bus.err_o          = r_err;
  assign bus.fault_o        = r_fault;
  assign bus.fsm_data_a_o   = r_data;
  assign bus.fsm_data_b_o   = r_data;
  assign bus.fsm_data_c_o   = r_data;
  assign bus.mismatch_cnt_o = r_mcnt;

endmodule
`default_nettype wire
